// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - issue stage with RAW scoreboard, forwarding-ready tracking and flush kill
// Instructions either issue or stall decode until every older producer they read is forwardable.
module issue_scoreboard #(
  parameter int NREGS      = 16,
  parameter int DEPTH      = 2,
  parameter int FLUSH_KILL = 1,
  parameter int CNT_W      = 16,
  localparam int RW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_insn,
  input  logic [NREGS-1:0] in_use_regs,
  input  logic             in_use_cpsr,
  input  logic [NREGS-1:0] in_def_regs,
  input  logic             in_def_cpsr,
  input  logic [RW-1:0]    in_ready_at,
  input  logic             in_cond_pass,
  output logic             stall_up,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_insn,
  output logic [CNT_W-1:0] stall_count
);

  localparam int DW = NREGS + 1;

  logic [DW-1:0]    r_def [DEPTH];
  logic [RW-1:0]    r_rdy [DEPTH];
  logic             r_out_valid;
  logic [31:0]      r_out_pc;
  logic [31:0]      r_out_insn;
  logic [CNT_W-1:0] r_cnt;

  logic [DW-1:0] w_use;
  logic [DW-1:0] w_def;
  logic          w_block;
  logic          w_hazard;
  logic          w_issue;
  logic [RW-1:0] w_rdy_in;

  // A producer in slot s is forwardable once s has reached its ready stage.
  always_comb begin
    w_use   = {in_use_cpsr, in_use_regs};
    w_def   = {in_def_cpsr, in_def_regs};
    w_block = 1'b0;
    for (int s = 0; s < DEPTH; s++) begin
      if ((|(w_use & r_def[s])) && (RW'(s) < r_rdy[s])) begin
        w_block = 1'b1;
      end
    end
  end

  assign w_hazard = in_valid & w_block & ~flush;
  assign w_issue  = in_valid & in_cond_pass;
  assign w_rdy_in = (in_ready_at > RW'(DEPTH)) ? RW'(DEPTH) : in_ready_at;
  assign stall_up = stall | w_hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_def[k] <= '0;
        r_rdy[k] <= '0;
      end
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_insn  <= '0;
      r_cnt       <= '0;
    end else if (flush) begin
      // The FLUSH_KILL youngest records are dropped while everything shifts one stage.
      r_out_valid <= 1'b0;
      r_def[0]    <= '0;
      r_rdy[0]    <= '0;
      for (int k = 1; k < DEPTH; k++) begin
        if (k > FLUSH_KILL) begin
          r_def[k] <= r_def[k-1];
          r_rdy[k] <= r_rdy[k-1];
        end else begin
          r_def[k] <= '0;
          r_rdy[k] <= '0;
        end
      end
    end else if (!stall) begin
      for (int k = 1; k < DEPTH; k++) begin
        r_def[k] <= r_def[k-1];
        r_rdy[k] <= r_rdy[k-1];
      end
      if (w_hazard) begin
        r_def[0]    <= '0;
        r_rdy[0]    <= '0;
        r_out_valid <= 1'b0;
        if (r_cnt != {CNT_W{1'b1}}) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_def[0]    <= w_issue ? w_def : '0;
        r_rdy[0]    <= w_issue ? w_rdy_in : '0;
        r_out_valid <= w_issue;
        r_out_pc    <= in_pc;
        r_out_insn  <= in_insn;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_pc      = r_out_pc;
  assign out_insn    = r_out_insn;
  assign stall_count = r_cnt;

endmodule
